// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Holds the controller state enum and width defaults.
package rf_arb_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int NREG   = 32;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Two-requester write-request bundle for the writeback arbiter.
// The master side drives requests; the slave side returns readies.
interface rf_wb_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          r0_valid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_data;
  logic          r0_ready;
  logic          r1_valid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_data;
  logic          r1_ready;

  modport master (
    output r0_valid, r0_addr, r0_data,
    output r1_valid, r1_addr, r1_data,
    input  r0_ready, r1_ready
  );

  modport slave (
    input  r0_valid, r0_addr, r0_data,
    input  r1_valid, r1_addr, r1_data,
    output r0_ready, r1_ready
  );
endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter producing a one-hot grant.
// ptr_i is the index granted last; the other side wins a tie.
module rr_arb2 (
  input  logic       v0_i,
  input  logic       v1_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      v0_i && v1_i:  gnt_o = ptr_i ? 2'b01 : 2'b10;
      v0_i && !v1_i: gnt_o = 2'b01;
      v1_i && !v0_i: gnt_o = 2'b10;
      default:       gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two round-robin requesters plus
// a clear sweep that zeroes registers 1..2^AW-1, one per cycle.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  rf_wb_arbiter_if.slave      req,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                RFWr,
  output logic [AW-1:0]       A3,
  output logic [DW-1:0]       WD,
  output logic                grant_id
);
  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          wr_q, wr_d;
  logic          gid_q, gid_d;
  logic [1:0]    arb_gnt;
  logic [1:0]    gnt;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  rr_arb2 u_arb (
    .v0_i  (req.r0_valid),
    .v1_i  (req.r1_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  assign gnt          = (state_q == IDLE) ? arb_gnt : 2'b00;
  assign req.r0_ready = gnt[0];
  assign req.r1_ready = gnt[1];
  assign sel_addr     = gnt[1] ? req.r1_addr : req.r0_addr;
  assign sel_data     = gnt[1] ? req.r1_data : req.r0_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    a3_d    = a3_q;
    wd_d    = wd_q;
    wr_d    = 1'b0;
    gid_d   = gid_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          // Register 0 is hardwired; accept but suppress the write.
          wr_d  = |sel_addr;
          a3_d  = sel_addr;
          wd_d  = sel_data;
          ptr_d = gnt[1];
          gid_d = gnt[1];
        end
        if (clr_req) state_d = CLEAR;
      end
      CLEAR: begin
        wr_d = 1'b1;
        a3_d = cnt_q;
        wd_d = '0;
        if (&cnt_q) begin
          state_d = IDLE;
          cnt_d   = AW'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= AW'(1);
      a3_q    <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      gid_q   <= gid_d;
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign RFWr     = wr_q;
  assign A3       = a3_q;
  assign WD       = wd_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a transaction-level model
// queues expected writes, a negedge monitor pops and compares them.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        clr_busy;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        grant_id;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.AW(5), .DW(32)) ifc ();

  rf_wb_arbiter #(.AW(5), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (ifc.slave),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .RFWr     (RFWr),
    .A3       (A3),
    .WD       (WD),
    .grant_id (grant_id)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 0;
  bit          pv[2];
  logic [4:0]  pa[2];
  logic [31:0] pd[2];
  int          busy_left = 0;
  int          last = 1;
  int          exp_gid = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (RFWr === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got A3=%0d WD=%0h expected none",
                   A3, WD);
        end else begin
          mon_e = q.pop_front();
          if (A3 !== mon_e.a || WD !== mon_e.d) begin
            errors++;
            $display("FAIL write: got A3=%0d WD=%0h expected A3=%0d WD=%0h",
                     A3, WD, mon_e.a, mon_e.d);
          end
        end
      end else if (RFWr !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL RFWr: got %b expected 0/1", RFWr);
      end
    end
  end

  task automatic load(int i, logic [4:0] a, logic [31:0] d);
    pv[i] = 1'b1;
    pa[i] = a;
    pd[i] = d;
  endtask

  task automatic cycle(bit clr, bit rstv);
    int w;
    wr_t e;
    @(negedge clk);
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, busy_left > 0});
    chk("grant_id", {31'd0, grant_id}, exp_gid);
    ifc.r0_valid = pv[0];
    ifc.r0_addr  = pa[0];
    ifc.r0_data  = pd[0];
    ifc.r1_valid = pv[1];
    ifc.r1_addr  = pa[1];
    ifc.r1_data  = pd[1];
    clr_req      = clr;
    rst          = rstv;
    #1;
    w = -1;
    if (busy_left == 0) begin
      if (pv[0] && pv[1]) w = (last == 1) ? 0 : 1;
      else if (pv[0]) w = 0;
      else if (pv[1]) w = 1;
    end
    chk("r0_ready", {31'd0, ifc.r0_ready}, {31'd0, w == 0});
    chk("r1_ready", {31'd0, ifc.r1_ready}, {31'd0, w == 1});
    if (!rstv) begin
      if (w >= 0) pv[w] = 1'b0;
      q.delete();
      busy_left = 0;
      last      = 1;
      exp_gid   = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (w >= 0) begin
        if (pa[w] != 0) begin
          e.a = pa[w];
          e.d = pd[w];
          q.push_back(e);
        end
        last    = w;
        exp_gid = w;
        pv[w]   = 1'b0;
      end
      if (clr) begin
        for (int r = 1; r < 32; r++) begin
          e.a = 5'(r);
          e.d = 32'd0;
          q.push_back(e);
        end
        busy_left = 31;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clr_req = 1'b0;
    ifc.r0_valid = 1'b0;
    ifc.r1_valid = 1'b0;
    ifc.r0_addr = '0;
    ifc.r1_addr = '0;
    ifc.r0_data = '0;
    ifc.r1_data = '0;
    pv[0] = 0;
    pv[1] = 0;
    repeat (3) @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    chk("reset_A3", {27'd0, A3}, 32'd0);
    chk("reset_WD", WD, 32'd0);
    chk("reset_RFWr", {31'd0, RFWr}, 32'd0);

    load(0, 5'd5, 32'h12345678);
    cycle(0, 1);
    repeat (2) cycle(0, 1);

    cycle(0, 0);
    for (int k = 0; k < 4; k++) begin
      if (!pv[0]) load(0, 5'd2, $urandom);
      if (!pv[1]) load(1, 5'd3, $urandom);
      cycle(0, 1);
    end
    pv[0] = 0;
    pv[1] = 0;
    repeat (2) cycle(0, 1);

    load(1, 5'd0, 32'hFFFFFFFF);
    repeat (3) cycle(0, 1);

    cycle(1, 1);
    load(0, 5'd9, 32'hCAFE0009);
    repeat (34) cycle(0, 1);

    load(0, 5'd7, 32'h000000A5);
    cycle(1, 1);
    repeat (34) cycle(0, 1);

    cycle(1, 1);
    repeat (10) cycle(0, 1);
    cycle(0, 0);
    repeat (5) cycle(0, 1);

    load(0, 5'd4, 32'hDEAD0004);
    cycle(0, 0);
    repeat (3) cycle(0, 1);

    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1)
          load(i, 5'($urandom_range(0, 31)), $urandom);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
    end

    pv[0] = 0;
    pv[1] = 0;
    repeat (40) cycle(0, 1);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
